// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory stage and its MEM/WB register.
// Optional build macro used by the stage: MEM_MISALIGN_TRAP_EN.
package mem_stage_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_REG_AW      = 5;
  localparam int DEF_TIMEOUT_CYC = 255;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  // A squashed slot only kills the control bits; data fields keep their last values.
  localparam wb_ctrl_t WB_CTRL_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0};

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads a new slot, inserts a bubble, or holds.
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              bubble_i,
  input  wb_ctrl_t          ctrl_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              rdata_en_i,
  input  logic [REG_AW-1:0] wreg_i,
  output logic              reg_write_o,
  output logic              mem_to_reg_o,
  output logic [DATA_W-1:0] read_data_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [REG_AW-1:0] wreg_o
);

  wb_ctrl_t          ctrl_q;
  logic [DATA_W-1:0] read_data_q;
  logic [DATA_W-1:0] read_data_d;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [REG_AW-1:0] wreg_q;

  // Read data only changes when a load actually completes.
  assign read_data_d = rdata_en_i ? rdata_i : read_data_q;

  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q      <= WB_CTRL_BUBBLE;
      read_data_q <= '0;
      alu_q       <= '0;
      wb_data_q   <= '0;
      wreg_q      <= '0;
    end else if (bubble_i) begin
      ctrl_q <= WB_CTRL_BUBBLE;
    end else if (load_i) begin
      ctrl_q      <= ctrl_i;
      read_data_q <= read_data_d;
      alu_q       <= alu_i;
      wb_data_q   <= ctrl_i.mem_to_reg ? read_data_d : alu_i;
      wreg_q      <= wreg_i;
    end
  end

  assign reg_write_o  = ctrl_q.reg_write;
  assign mem_to_reg_o = ctrl_q.mem_to_reg;
  assign read_data_o  = read_data_q;
  assign alu_o        = alu_q;
  assign wb_data_o    = wb_data_q;
  assign wreg_o       = wreg_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage with req/ready data-memory handshake, timeout abort and MEM/WB register.
// Build macro MEM_MISALIGN_TRAP_EN: trap word-misaligned accesses and add MisalignErr.
module mem_wb_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int REG_AW      = DEF_REG_AW,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemToReg,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteMemData,
  input  logic [REG_AW-1:0] WriteReg,
  input  logic              Flush,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              Stall,
  output logic              MemTimeout,
  output logic              RegWrite_out,
  output logic              MemToReg_out,
  output logic [DATA_W-1:0] ReadData_out,
  output logic [DATA_W-1:0] ALUResult_out,
  output logic [REG_AW-1:0] WriteReg_out,
  output logic [DATA_W-1:0] WBData_out
`ifdef MEM_MISALIGN_TRAP_EN
  ,output logic             MisalignErr
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  logic     mem_access;
  logic     trap;
  logic     memop;
  logic     abort_cyc;
  logic     abort;
  logic     mem_done;
  logic     kill;
  wb_ctrl_t wb_ctrl;

  assign mem_access = (MemRead | MemWrite) & ~Flush;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  assign trap        = mem_access & (ALUResult[1:0] != 2'b00);
  assign MisalignErr = misalign_q;
`else
  assign trap = 1'b0;
`endif

  assign memop = mem_access & ~trap;

  // The last WAIT cycle never drives a request, so a late ready cannot race the abort.
  assign abort_cyc = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYC));
  assign abort     = memop & abort_cyc;

  assign dmem_req   = memop & ~abort_cyc & ~rst;
  assign dmem_we    = MemWrite;
  assign dmem_addr  = ALUResult;
  assign dmem_wdata = WriteMemData;

  assign mem_done = dmem_req & dmem_ready;
  assign Stall    = dmem_req & ~dmem_ready;

  // Anything that does not retire this cycle enters MEM/WB as a bubble.
  assign kill    = Flush | trap | Stall | abort;
  assign wb_ctrl = '{reg_write: RegWrite & ~MemWrite, mem_to_reg: MemToReg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= trap;
`endif
      case (state_q)
        IDLE: begin
          if (Stall) begin
            state_q <= WAIT;
            cnt_q   <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (Stall) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            // Completion, flush and abort all return to IDLE.
            state_q <= IDLE;
            cnt_q   <= '0;
            if (abort) timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign MemTimeout = timeout_q;

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_mem_wb_reg (
    .clk          (clk),
    .rst          (rst),
    .load_i       (~kill),
    .bubble_i     (kill),
    .ctrl_i       (wb_ctrl),
    .alu_i        (ALUResult),
    .rdata_i      (dmem_rdata),
    .rdata_en_i   (mem_done & ~MemWrite),
    .wreg_i       (WriteReg),
    .reg_write_o  (RegWrite_out),
    .mem_to_reg_o (MemToReg_out),
    .read_data_o  (ReadData_out),
    .alu_o        (ALUResult_out),
    .wb_data_o    (WBData_out),
    .wreg_o       (WriteReg_out)
  );

endmodule
